match_scorer: RTL and testbench

Round controller and score keeper that sits directly downstream of the 3-bit equality comparator in the mini-project game datapath. Each round it requests a new target from the upstream generator, waits for the player's guess strobe, samples the comparator's 4-bit `equal` result, updates a two-digit BCD score, and shows hit/miss feedback for a fixed interval. After `ROUNDS` rounds it halts in a game-over state until restarted.

---
 rtl/match_pkg.sv | 28 ++
 rtl/bcd_sat_counter.sv | 61 ++++++
 rtl/match_scorer.sv | 179 +++++++++++++++++
 tb/tb_match_scorer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// match_pkg - shared types and constants for the match_scorer game block.
//   state_t      : round controller states
//   bcd_t        : one BCD digit
//   BCD_MAX      : largest legal BCD digit value
//   SCORE_MAX    : saturation limit of the two-digit score
//   bcd_to_bin() : two BCD digits -> binary value
package match_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_GUESS,
    EVAL,
    SHOW,
    DONE
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t       BCD_MAX   = 4'd9;
  localparam logic [7:0] SCORE_MAX = 8'd99;

  function automatic logic [7:0] bcd_to_bin(input bcd_t tens, input bcd_t ones);
    // tens*10 + ones, written as shifts to stay in 8 bits
    return ({4'd0, tens} << 3) + ({4'd0, tens} << 1) + {4'd0, ones};
  endfunction

endpackage

// File: rtl/bcd_sat_counter.sv
// bcd_sat_counter - two-digit BCD counter that saturates at 99.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear to 00 (wins over inc)
//   inc       : add to the score this cycle
//   inc_two   : when inc is set, add 2 instead of 1
//   ones/tens : BCD digits of the current count
module bcd_sat_counter
  import match_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       inc_two,
  output logic [3:0] ones,
  output logic [3:0] tens
);

  bcd_t       ones_reg, ones_next;
  bcd_t       tens_reg, tens_next;
  logic [4:0] ones_sum;
  logic [7:0] total;

  always_comb begin
    ones_next = ones_reg;
    tens_next = tens_reg;
    ones_sum  = {1'b0, ones_reg} + (inc_two ? 5'd2 : 5'd1);
    total     = bcd_to_bin(tens_reg, ones_reg) + (inc_two ? 8'd2 : 8'd1);
    if (clr) begin
      ones_next = '0;
      tens_next = '0;
    end else if (inc) begin
      // Check the binary total first so 98+2 and 99+n pin at 99
      // instead of carrying out of the tens digit.
      if (total >= SCORE_MAX) begin
        ones_next = BCD_MAX;
        tens_next = BCD_MAX;
      end else if (ones_sum > {1'b0, BCD_MAX}) begin
        ones_next = 4'(ones_sum - 5'd10);
        tens_next = tens_reg + 4'd1;
      end else begin
        ones_next = ones_sum[3:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_reg <= '0;
      tens_reg <= '0;
    end else begin
      ones_reg <= ones_next;
      tens_reg <= tens_next;
    end
  end

  assign ones = ones_reg;
  assign tens = tens_reg;

endmodule

// File: rtl/match_scorer.sv
// match_scorer - round controller and BCD score keeper for the guessing game.
// Optional feature macro: MATCH_STREAK_EN (every third consecutive hit scores 2).
// Parameters: ROUNDS (1..15) rounds per game, SHOW_CYCLES (>=1) feedback length.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (back to IDLE)
//   start       : begin a game from IDLE or DONE
//   guess_valid : one-cycle strobe, equal[0] valid with it
//   equal       : comparator result, only bit 0 is used
//   round_start : one-cycle pulse asking upstream for a new target
//   round_num   : current round 1..ROUNDS, 0 when idle
//   score_ones/score_tens : BCD score
//   hit/miss    : feedback held for SHOW_CYCLES cycles
//   game_over   : high in DONE
module match_scorer
  import match_pkg::*;
#(
  parameter int ROUNDS      = 8,
  parameter int SHOW_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       guess_valid,
  input  logic [3:0] equal,
  output logic       round_start,
  output logic [3:0] round_num,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic       hit,
  output logic       miss,
  output logic       game_over
);

  localparam int                  TIMER_W    = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TIMER_W-1:0]  SHOW_LOAD  = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [3:0]          LAST_ROUND = 4'(ROUNDS);

  state_t             state_reg, state_next;
  logic [3:0]         round_num_reg, round_num_next;
  logic               round_start_reg, round_start_next;
  logic               hit_reg, hit_next;
  logic               miss_reg, miss_next;
  logic               game_over_reg, game_over_next;
  logic               match_reg, match_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic               score_clr, score_inc, score_two;
`ifdef MATCH_STREAK_EN
  logic [1:0]         streak_reg, streak_next;
`endif

  // Only the match bit carries meaning; the upper comparator bits are dropped.
  logic unused_equal_bits;
  assign unused_equal_bits = ^equal[3:1];

  always_comb begin
    state_next       = state_reg;
    round_num_next   = round_num_reg;
    round_start_next = 1'b0;
    hit_next         = hit_reg;
    miss_next        = miss_reg;
    game_over_next   = game_over_reg;
    match_next       = match_reg;
    timer_next       = timer_reg;
    score_clr        = 1'b0;
    score_inc        = 1'b0;
    score_two        = 1'b0;
`ifdef MATCH_STREAK_EN
    streak_next      = streak_reg;
`endif
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next     = REQ;
          round_num_next = 4'd1;
          game_over_next = 1'b0;
          score_clr      = 1'b1;
`ifdef MATCH_STREAK_EN
          streak_next    = 2'd0;
`endif
        end
      end
      REQ: begin
        // round_start is registered, so it is seen the cycle after REQ;
        // a guess present during REQ itself is never sampled.
        round_start_next = 1'b1;
        state_next       = WAIT_GUESS;
      end
      WAIT_GUESS: begin
        if (guess_valid) begin
          match_next = equal[0];
          state_next = EVAL;
        end
      end
      EVAL: begin
        timer_next = SHOW_LOAD;
        state_next = SHOW;
        if (match_reg) begin
          hit_next  = 1'b1;
          score_inc = 1'b1;
`ifdef MATCH_STREAK_EN
          if (streak_reg == 2'd2) begin
            score_two   = 1'b1;
            streak_next = 2'd0;
          end else begin
            streak_next = streak_reg + 2'd1;
          end
`endif
        end else begin
          miss_next   = 1'b1;
`ifdef MATCH_STREAK_EN
          streak_next = 2'd0;
`endif
        end
      end
      SHOW: begin
        if (timer_reg == '0) begin
          hit_next  = 1'b0;
          miss_next = 1'b0;
          if (round_num_reg == LAST_ROUND) begin
            state_next     = DONE;
            game_over_next = 1'b1;
          end else begin
            round_num_next = round_num_reg + 4'd1;
            state_next     = REQ;
          end
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      round_num_reg   <= '0;
      round_start_reg <= 1'b0;
      hit_reg         <= 1'b0;
      miss_reg        <= 1'b0;
      game_over_reg   <= 1'b0;
      match_reg       <= 1'b0;
      timer_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      round_num_reg   <= round_num_next;
      round_start_reg <= round_start_next;
      hit_reg         <= hit_next;
      miss_reg        <= miss_next;
      game_over_reg   <= game_over_next;
      match_reg       <= match_next;
      timer_reg       <= timer_next;
    end
  end

`ifdef MATCH_STREAK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak_reg <= 2'd0;
    else     streak_reg <= streak_next;
  end
`endif

  bcd_sat_counter u_score (
    .clk     (clk),
    .rst     (rst),
    .clr     (score_clr),
    .inc     (score_inc),
    .inc_two (score_two),
    .ones    (score_ones),
    .tens    (score_tens)
  );

  assign round_start = round_start_reg;
  assign round_num   = round_num_reg;
  assign hit         = hit_reg;
  assign miss        = miss_reg;
  assign game_over   = game_over_reg;

endmodule

// File: tb/tb_match_scorer.sv
// tb_match_scorer - directed bench for match_scorer (ROUNDS=3/SHOW_CYCLES=4 and
// ROUNDS=12/SHOW_CYCLES=1 instances) plus a direct bcd_sat_counter instance
// for the saturation corner. Honours MATCH_STREAK_EN in its score model.
module tb_match_scorer;

  localparam int SHOW = 4;

  logic       clk, rst;
  logic       start, guess_valid;
  logic [3:0] equal;
  logic       round_start, hit, miss, game_over;
  logic [3:0] round_num, score_ones, score_tens;

  logic       start2, guess2;
  logic [3:0] equal2;
  logic       round_start2, hit2, miss2, game_over2;
  logic [3:0] round_num2, ones2, tens2;

  logic       clr_c, inc_c, two_c;
  logic [3:0] ones_c, tens_c;

  int checks = 0;
  int errors = 0;

  match_scorer #(.ROUNDS(3), .SHOW_CYCLES(SHOW)) dut (
    .clk(clk), .rst(rst), .start(start), .guess_valid(guess_valid), .equal(equal),
    .round_start(round_start), .round_num(round_num), .score_ones(score_ones),
    .score_tens(score_tens), .hit(hit), .miss(miss), .game_over(game_over)
  );

  match_scorer #(.ROUNDS(12), .SHOW_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .guess_valid(guess2), .equal(equal2),
    .round_start(round_start2), .round_num(round_num2), .score_ones(ones2),
    .score_tens(tens2), .hit(hit2), .miss(miss2), .game_over(game_over2)
  );

  bcd_sat_counter cnt (
    .clk(clk), .rst(rst), .clr(clr_c), .inc(inc_c), .inc_two(two_c),
    .ones(ones_c), .tens(tens_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected score after n consecutive hits from a fresh game.
  function automatic int model_score(input int n);
`ifdef MATCH_STREAK_EN
    return 4 * (n / 3) + (n % 3);
`else
    return n;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_score(input string tag, input int exp);
    check({tag, "_ones"}, int'(score_ones), exp % 10);
    check({tag, "_tens"}, int'(score_tens), exp / 10);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_round_start"}, int'(round_start), 0);
    check({tag, "_round_num"}, int'(round_num), 0);
    check_score(tag, 0);
    check({tag, "_hit"}, int'(hit), 0);
    check({tag, "_miss"}, int'(miss), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
  endtask

  // Entered with dut in WAIT_GUESS; leaves at the sample where round_start
  // is high again (or, on the last round, where game_over has just risen).
  task automatic do_round(input string tag, input logic [3:0] eq, input bit stray,
                          input bit exp_hit, input int exp_score, input int rn,
                          input bit last);
    int n;
    check({tag, "_rnum"}, int'(round_num), rn);
    guess_valid = 1'b1;
    equal       = eq;
    step();
    guess_valid = 1'b0;
    equal       = 4'd0;
    check({tag, "_eval_quiet"}, int'(hit | miss), 0);
    step();
    check({tag, "_hit"}, int'(hit), int'(exp_hit));
    check({tag, "_miss"}, int'(miss), int'(!exp_hit));
    check_score(tag, exp_score);
    n = 1;
    if (stray) begin
      guess_valid = 1'b1;
      equal       = eq;
    end
    for (int i = 0; i < 20; i++) begin
      step();
      guess_valid = 1'b0;
      equal       = 4'd0;
      if (hit | miss) n++;
      else break;
    end
    check({tag, "_show_len"}, n, SHOW);
    check_score({tag, "_after"}, exp_score);
    if (last) begin
      check({tag, "_game_over"}, int'(game_over), 1);
      check({tag, "_final_rnum"}, int'(round_num), rn);
    end else begin
      step();
      check({tag, "_next_rs"}, int'(round_start), 1);
      check({tag, "_next_rnum"}, int'(round_num), rn + 1);
    end
    $display("round %s: eq=%b hit=%0d score=%0d%0d", tag, eq, exp_hit, score_tens, score_ones);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; guess_valid = 1'b0; equal = 4'd0;
    start2 = 1'b0; guess2 = 1'b0; equal2 = 4'd0;
    clr_c = 1'b0; inc_c = 1'b0; two_c = 1'b0;
    step();
    step();
    check_idle("reset");
    rst = 1'b0;
    step();
    check_idle("idle_hold");

    // ---- game 1: hit, miss (upper bits set), hit ----
    start = 1'b1;
    step();
    start = 1'b0;
    guess_valid = 1'b1;   // arrives during REQ, must be ignored
    equal = 4'b0001;
    check("g1_rnum_req", int'(round_num), 1);
    check("g1_rs_req", int'(round_start), 0);
    step();
    guess_valid = 1'b0;
    equal = 4'd0;
    check("g1_rs_pulse", int'(round_start), 1);
    start = 1'b1;         // ignored in WAIT_GUESS
    step();
    start = 1'b0;
    check("g1_rs_single", int'(round_start), 0);
    check("g1_rnum_hold", int'(round_num), 1);
    step();
    check("g1_no_early_hit", int'(hit | miss), 0);
    check_score("g1_no_early_score", 0);
    do_round("g1r1", 4'b0001, 1'b1, 1'b1, 1, 1, 1'b0);
    do_round("g1r2", 4'b1110, 1'b0, 1'b0, 1, 2, 1'b0);
    do_round("g1r3", 4'b0001, 1'b0, 1'b1, 2, 3, 1'b1);

    guess_valid = 1'b1;
    equal = 4'b0001;
    step();
    guess_valid = 1'b0;
    equal = 4'd0;
    step();
    step();
    check("done_game_over", int'(game_over), 1);
    check("done_rnum", int'(round_num), 3);
    check("done_hit", int'(hit), 0);
    check_score("done_score", 2);

    // ---- game 2: three hits from DONE ----
    start = 1'b1;
    step();
    start = 1'b0;
    check_score("g2_clear", 0);
    check("g2_game_over_clr", int'(game_over), 0);
    check("g2_rnum", int'(round_num), 1);
    step();
    check("g2_rs", int'(round_start), 1);
    do_round("g2r1", 4'b0001, 1'b0, 1'b1, model_score(1), 1, 1'b0);
    do_round("g2r2", 4'b0011, 1'b0, 1'b1, model_score(2), 2, 1'b0);
    do_round("g2r3", 4'b1111, 1'b0, 1'b1, model_score(3), 3, 1'b1);

    // ---- reset asserted mid-SHOW ----
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    guess_valid = 1'b1;
    equal = 4'b0001;
    step();
    guess_valid = 1'b0;
    equal = 4'd0;
    step();
    step();
    check("pre_rst_hit", int'(hit), 1);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    step();
    rst = 1'b0;
    step();
    step();
    check_idle("post_rst");
    $display("reset mid-show: outputs cleared");

    // ---- dut2: 12 consecutive hits, carry 09 -> 10 ----
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int r = 1; r <= 12; r++) begin
      for (int i = 0; i < 10; i++) begin
        step();
        if (round_start2) break;
      end
      check("d2_rs", int'(round_start2), 1);
      guess2 = 1'b1;
      equal2 = 4'b0001;
      step();
      guess2 = 1'b0;
      equal2 = 4'd0;
      step();
      check("d2_ones", int'(ones2), model_score(r) % 10);
      check("d2_tens", int'(tens2), model_score(r) / 10);
      $display("dut2 round %0d: score=%0d%0d", r, tens2, ones2);
    end
    for (int i = 0; i < 10; i++) begin
      if (game_over2) break;
      step();
    end
    check("d2_game_over", int'(game_over2), 1);
    check("d2_rnum", int'(round_num2), 12);

    // ---- counter: carry and saturation ----
    clr_c = 1'b1;
    step();
    clr_c = 1'b0;
    inc_c = 1'b1;
    for (int i = 0; i < 8; i++) step();
    inc_c = 1'b0;
    check("c_08_ones", int'(ones_c), 8);
    inc_c = 1'b1;
    two_c = 1'b1;
    step();
    two_c = 1'b0;
    check("c_08p2_ones", int'(ones_c), 0);
    check("c_08p2_tens", int'(tens_c), 1);
    for (int i = 0; i < 88; i++) step();
    inc_c = 1'b0;
    check("c_98_ones", int'(ones_c), 8);
    check("c_98_tens", int'(tens_c), 9);
    inc_c = 1'b1;
    two_c = 1'b1;
    step();
    check("c_98p2_ones", int'(ones_c), 9);
    check("c_98p2_tens", int'(tens_c), 9);
    two_c = 1'b0;
    step();
    step();
    check("c_sat_ones", int'(ones_c), 9);
    check("c_sat_tens", int'(tens_c), 9);
    inc_c = 1'b0;
    clr_c = 1'b1;
    step();
    clr_c = 1'b0;
    check("c_clr", int'({tens_c, ones_c}), 0);
    $display("counter: saturation at 99 exercised");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
